// File: rtl/seg_io_ctrl.sv
// seg_io_ctrl: memory-mapped seven-segment display and debounced up/down button counter
module seg_io_ctrl #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0400,
  parameter int          REFRESH_DIV     = 50000,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic [31:0] read_address,
  output logic [31:0] io_data,
  output logic        io_hit,
  input  logic        button_up,
  input  logic        button_down,
  output logic        seg_c1,
  output logic        seg_c2,
  output logic        seg_c3,
  output logic        seg_c4,
  output logic        seg_a,
  output logic        seg_b,
  output logic        seg_c,
  output logic        seg_d,
  output logic        seg_e,
  output logic        seg_f,
  output logic        seg_g,
  output logic        seg_h
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  logic [1:0]    sync1_q, sync2_q, acc_q, press;
  logic [DW-1:0] db_cnt_q [2];
  logic [15:0]   disp_q, count_q, count_d;
  logic [1:0]    seen_q, seen_d;
  logic [31:0]   io_data_d;
  logic          wr_disp, wr_count, rd_disp, rd_count, rd_status;
  logic [RW-1:0] ref_q;
  logic [1:0]    dig_q;
  logic [3:0]    an_q, nib;
  logic [6:0]    seg_q;
  logic          unused_wdata;

  assign unused_wdata = ^write_data[31:16];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h7E;
      4'h1: hex7 = 7'h30;
      4'h2: hex7 = 7'h6D;
      4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;
      4'h5: hex7 = 7'h5B;
      4'h6: hex7 = 7'h5F;
      4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h7B;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;
      4'hD: hex7 = 7'h3D;
      4'hE: hex7 = 7'h4F;
      default: hex7 = 7'h47;
    endcase
  endfunction

  // press pulse fires on the edge where an accepted 0 level flips to 1
  always_comb begin
    for (int i = 0; i < 2; i++) press[i] = sync2_q[i] & ~acc_q[i] & (db_cnt_q[i] == DB_LAST);
  end

  // synchronize raw pins and accept a new level once it has been stable long enough
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      acc_q   <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= {button_down, button_up};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == acc_q[i]) db_cnt_q[i] <= '0;
        else if (db_cnt_q[i] == DB_LAST) begin
          acc_q[i]    <= ~acc_q[i];
          db_cnt_q[i] <= '0;
        end else db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
      end
    end
  end

  // exact-match register decode, counter/flag next state and read mux
  always_comb begin
    wr_disp   = mem_write && write_address == BASE_ADDR;
    wr_count  = mem_write && write_address == BASE_ADDR + 32'd4;
    rd_disp   = mem_read && read_address == BASE_ADDR;
    rd_count  = mem_read && read_address == BASE_ADDR + 32'd4;
    rd_status = mem_read && read_address == BASE_ADDR + 32'd8;
    count_d   = wr_count ? write_data[15:0] :
                press == 2'b01 ? count_q + 16'd1 :
                press == 2'b10 ? count_q - 16'd1 : count_q;
    seen_d    = press | (rd_status ? 2'b00 : seen_q);
    io_data_d = rd_disp ? {16'h0, disp_q} :
                rd_count ? {16'h0, count_q} :
                rd_status ? {30'h0, seen_q} : 32'h0;
  end

  // CPU-visible registers and registered read port
  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q  <= '0;
      count_q <= '0;
      seen_q  <= '0;
      io_data <= '0;
      io_hit  <= 1'b0;
    end else begin
      if (wr_disp) disp_q <= write_data[15:0];
      count_q <= count_d;
      seen_q  <= seen_d;
      io_data <= io_data_d;
      io_hit  <= rd_disp | rd_count | rd_status;
    end
  end

  // nibble for the digit currently being scanned, c1 = most significant
  always_comb begin
    nib = dig_q == 2'd0 ? disp_q[15:12] :
          dig_q == 2'd1 ? disp_q[11:8] :
          dig_q == 2'd2 ? disp_q[7:4] : disp_q[3:0];
  end

  // refresh timer, digit rotation and registered active-low drive
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_q <= '0;
      dig_q <= '0;
      an_q  <= 4'hF;
      seg_q <= 7'h7F;
    end else begin
      ref_q <= ref_q == REF_LAST ? '0 : ref_q + 1'b1;
      if (ref_q == REF_LAST) dig_q <= dig_q + 2'd1;
      an_q  <= ~(4'b1000 >> dig_q);
      seg_q <= ~hex7(nib);
    end
  end

  assign {seg_c1, seg_c2, seg_c3, seg_c4} = an_q;
  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg_q;
  assign seg_h = 1'b1;
endmodule

// File: tb/tb_seg_io_ctrl.sv
// tb_seg_io_ctrl: directed and random stimulus against a cycle-level reference model
module tb_seg_io_ctrl;
  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int DIV = 4;
  localparam int DB  = 8;
  localparam bit [6:0] HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  logic clk = 0, reset = 1, mem_write = 0, mem_read = 0, button_up = 0, button_down = 0;
  logic [31:0] write_address = 0, write_data = 0, read_address = 0;
  logic [31:0] io_data;
  logic io_hit, seg_c1, seg_c2, seg_c3, seg_c4;
  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_h;

  always #5 clk = ~clk;

  seg_io_ctrl #(.BASE_ADDR(BASE), .REFRESH_DIV(DIV), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .write_address(write_address), .write_data(write_data), .read_address(read_address),
    .io_data(io_data), .io_hit(io_hit), .button_up(button_up), .button_down(button_down),
    .seg_c1(seg_c1), .seg_c2(seg_c2), .seg_c3(seg_c3), .seg_c4(seg_c4),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d), .seg_e(seg_e),
    .seg_f(seg_f), .seg_g(seg_g), .seg_h(seg_h)
  );

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] m_disp, m_count;
  logic [1:0]  m_seen, m_acc;
  logic [31:0] m_hu, m_hd, m_data;
  logic        m_hit;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  int          m_t;

  // a level is accepted once DB consecutive pin samples, ending two edges back, all oppose it
  function automatic logic flips(input logic [31:0] h, input logic acc);
    logic [DB-1:0] w;
    w = h[DB+1:2];
    return acc ? (w == '0) : (&w);
  endfunction

  task automatic model_edge();
    logic [1:0] p;
    logic fu, fd;
    int d;
    logic [3:0] nib;
    if (reset) begin
      m_disp = 0; m_count = 0; m_seen = 0; m_acc = 0; m_hu = 0; m_hd = 0;
      m_data = 0; m_hit = 0; m_an = 4'hF; m_seg = 7'h7F; m_t = 0;
    end else begin
      m_hu = {m_hu[30:0], button_up};
      m_hd = {m_hd[30:0], button_down};
      fu = flips(m_hu, m_acc[0]);
      fd = flips(m_hd, m_acc[1]);
      p = {fd & ~m_acc[1], fu & ~m_acc[0]};
      m_acc = m_acc ^ {fd, fu};
      d = (m_t / DIV) % 4;
      nib = 4'(m_disp >> (12 - 4 * d));
      m_an = ~(4'b1000 >> d);
      m_seg = ~HEX[nib];
      m_t++;
      m_hit = mem_read && (read_address == BASE || read_address == BASE + 4 || read_address == BASE + 8);
      m_data = !mem_read ? 32'h0 : read_address == BASE ? {16'h0, m_disp} :
               read_address == BASE + 4 ? {16'h0, m_count} :
               read_address == BASE + 8 ? {30'h0, m_seen} : 32'h0;
      m_seen = ((mem_read && read_address == BASE + 8) ? 2'b00 : m_seen) | p;
      if (mem_write && write_address == BASE + 4) m_count = write_data[15:0];
      else m_count = m_count + 16'(p[0]) - 16'(p[1]);
      if (mem_write && write_address == BASE) m_disp = write_data[15:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("io_data", io_data, m_data);
    check("io_hit", io_hit, {31'h0, m_hit});
    check("enables", {28'h0, seg_c1, seg_c2, seg_c3, seg_c4}, {28'h0, m_an});
    check("segments", {25'h0, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, {25'h0, m_seg});
    check("seg_h", {31'h0, seg_h}, 32'h1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    mem_write = 1; write_address = a; write_data = v;
    tick();
    mem_write = 0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_read = 1; read_address = a;
    tick();
    mem_read = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return BASE;
      1: return BASE + 4;
      2: return BASE + 8;
      3: return BASE + 12;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) tick();
    check("reset_enables", {28'h0, seg_c1, seg_c2, seg_c3, seg_c4}, 32'hF);
    reset = 0;
    tick();
    check("first_digit_c1", {31'h0, seg_c1}, 32'h0);
    wr(BASE, 32'hDEAD_1A2F);
    repeat (20) tick();
    rd(BASE);
    check("disp_read", io_data, 32'h0000_1A2F);
    mem_read = 1; read_address = BASE + 4;
    button_up = 1; repeat (5) tick();
    button_up = 0; repeat (3) tick();
    button_up = 1; repeat (20) tick();
    button_up = 0; repeat (12) tick();
    check("count_after_bounce", io_data, 32'h1);
    mem_read = 0;
    rd(BASE + 8);
    check("status_set", io_data, 32'h1);
    rd(BASE + 8);
    check("status_cleared", io_data, 32'h0);
    wr(BASE + 4, 32'h0000_FFFF);
    button_up = 1; repeat (14) tick();
    button_up = 0; repeat (14) tick();
    rd(BASE + 4);
    check("count_wrap_up", io_data, 32'h0);
    button_down = 1; repeat (14) tick();
    button_down = 0; repeat (14) tick();
    rd(BASE + 4);
    check("count_wrap_down", io_data, 32'hFFFF);
    rd(BASE + 8);
    check("status_both", io_data, 32'h3);
    button_up = 1; button_down = 1; repeat (14) tick();
    button_up = 0; button_down = 0; repeat (14) tick();
    rd(BASE + 4);
    check("count_aligned", io_data, 32'hFFFF);
    rd(BASE + 8);
    check("status_aligned", io_data, 32'h3);
    button_up = 1; repeat (9) tick();
    wr(BASE + 4, 32'h1234_0050);
    repeat (4) tick();
    button_up = 0; repeat (12) tick();
    rd(BASE + 4);
    check("count_cpu_wins", io_data, 32'h50);
    rd(BASE + 8);
    check("status_up_kept", io_data, 32'h1);
    button_down = 1; repeat (9) tick();
    rd(BASE + 8);
    check("status_old_value", io_data, 32'h0);
    repeat (3) tick();
    rd(BASE + 8);
    check("status_set_wins", io_data, 32'h2);
    button_down = 0; repeat (12) tick();
    wr(BASE + 8, 32'hFFFF_FFFF);
    rd(BASE + 8);
    check("status_write_ignored", io_data, 32'h0);
    rd(BASE + 12);
    check("hit_base12", {31'h0, io_hit}, 32'h0);
    rd(32'h0);
    rd(BASE + 1);
    rd(32'h0001_0400);
    check("data_unmatched", io_data, 32'h0);
    repeat (6) tick();
    reset = 1;
    tick();
    check("midscan_reset", {28'h0, seg_c1, seg_c2, seg_c3, seg_c4}, 32'hF);
    reset = 0;
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) button_up = ~button_up;
      if ($urandom_range(0, 9) == 0) button_down = ~button_down;
      mem_write = $urandom_range(0, 3) == 0;
      write_address = pick_addr();
      write_data = $urandom;
      mem_read = $urandom_range(0, 1) == 1;
      read_address = pick_addr();
      reset = $urandom_range(0, 499) == 0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
